// File: rtl/core_memory_arbiter_pkg.sv
// Shared types and constants for the core memory arbiter: FSM state encoding,
// bus widths and the read value returned on a timed-out access.
package core_memory_arbiter_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    localparam logic [DATA_WIDTH-1:0] MEM_ERROR_DATA = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_INSTR_ACTIVE,
        ARB_DATA_ACTIVE,
        ARB_INSTR_DONE,
        ARB_DATA_DONE
    } arb_state_t;

endpackage

// File: rtl/core_memory_arbiter_timeout.sv
// Bus watchdog: counts unacknowledged active cycles and flags expiry on the
// last allowed cycle so the arbiter can force an error completion.
module memory_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [15:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + 16'd1;
        end
    end

    // Expiry is seen during the N-th active cycle, giving exactly N cycles of wait.
    assign expired = (count_reg == 16'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/core_memory_arbiter.sv
// Round-robin arbiter sharing one external memory port between instruction
// fetch and data load/store, with a watchdog that forces error completion.
module core_memory_arbiter
    import core_memory_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_request,
    input  logic [ADDR_WIDTH-1:0] instr_address,
    output logic [DATA_WIDTH-1:0] instr_readData,
    output logic                  instr_busy,
    output logic                  instr_error,
    input  logic                  data_request,
    input  logic                  data_writeEnable,
    input  logic [3:0]            data_byteSelect,
    input  logic [ADDR_WIDTH-1:0] data_address,
    input  logic [DATA_WIDTH-1:0] data_writeData,
    output logic [DATA_WIDTH-1:0] data_readData,
    output logic                  data_busy,
    output logic                  data_error,
    output logic                  mem_cycle,
    output logic                  mem_writeEnable,
    output logic [3:0]            mem_byteSelect,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_writeData,
    input  logic [DATA_WIDTH-1:0] mem_readData,
    input  logic                  mem_ack
);

    arb_state_t            state_reg, state_next;
    logic                  last_grant_data_reg, last_grant_data_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic                  we_reg, we_next;
    logic [3:0]            bs_reg, bs_next;
    logic [DATA_WIDTH-1:0] wd_reg, wd_next;
    logic [DATA_WIDTH-1:0] instr_rd_reg, instr_rd_next;
    logic [DATA_WIDTH-1:0] data_rd_reg, data_rd_next;
    logic                  instr_err_reg, instr_err_next;
    logic                  data_err_reg, data_err_next;

    logic active;
    logic expired;

    assign active = (state_reg == ARB_INSTR_ACTIVE) || (state_reg == ARB_DATA_ACTIVE);

    memory_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_reg == ARB_IDLE),
        .enable (active && !mem_ack),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg           <= ARB_IDLE;
            last_grant_data_reg <= 1'b0;
            addr_reg            <= '0;
            we_reg              <= 1'b0;
            bs_reg              <= '0;
            wd_reg              <= '0;
            instr_rd_reg        <= '0;
            data_rd_reg         <= '0;
            instr_err_reg       <= 1'b0;
            data_err_reg        <= 1'b0;
        end else begin
            state_reg           <= state_next;
            last_grant_data_reg <= last_grant_data_next;
            addr_reg            <= addr_next;
            we_reg              <= we_next;
            bs_reg              <= bs_next;
            wd_reg              <= wd_next;
            instr_rd_reg        <= instr_rd_next;
            data_rd_reg         <= data_rd_next;
            instr_err_reg       <= instr_err_next;
            data_err_reg        <= data_err_next;
        end
    end

    always_comb begin
        state_next           = state_reg;
        last_grant_data_next = last_grant_data_reg;
        addr_next            = addr_reg;
        we_next              = we_reg;
        bs_next              = bs_reg;
        wd_next              = wd_reg;
        instr_rd_next        = instr_rd_reg;
        data_rd_next         = data_rd_reg;
        instr_err_next       = 1'b0;
        data_err_next        = 1'b0;

        case (state_reg)
            ARB_IDLE: begin
                // Data wins when alone or when instruction fetch was granted last.
                if (data_request && (!instr_request || !last_grant_data_reg)) begin
                    state_next           = ARB_DATA_ACTIVE;
                    last_grant_data_next = 1'b1;
                    addr_next            = data_address;
                    we_next              = data_writeEnable;
                    bs_next              = data_byteSelect;
                    wd_next              = data_writeData;
                end else if (instr_request) begin
                    state_next           = ARB_INSTR_ACTIVE;
                    last_grant_data_next = 1'b0;
                    addr_next            = instr_address;
                    we_next              = 1'b0;
                    bs_next              = 4'hF;
                    wd_next              = '0;
                end
            end
            ARB_INSTR_ACTIVE: begin
                // A requester that has withdrawn gets neither data nor an error.
                if (mem_ack) begin
                    state_next = ARB_INSTR_DONE;
                    if (instr_request) instr_rd_next = mem_readData;
                end else if (expired) begin
                    state_next = ARB_INSTR_DONE;
                    if (instr_request) begin
                        instr_rd_next  = MEM_ERROR_DATA;
                        instr_err_next = 1'b1;
                    end
                end
            end
            ARB_DATA_ACTIVE: begin
                if (mem_ack) begin
                    state_next = ARB_DATA_DONE;
                    if (data_request) data_rd_next = mem_readData;
                end else if (expired) begin
                    state_next = ARB_DATA_DONE;
                    if (data_request) begin
                        data_rd_next  = MEM_ERROR_DATA;
                        data_err_next = 1'b1;
                    end
                end
            end
            ARB_INSTR_DONE: state_next = ARB_IDLE;
            ARB_DATA_DONE:  state_next = ARB_IDLE;
            default:        state_next = ARB_IDLE;
        endcase
    end

    assign mem_cycle       = active;
    assign mem_writeEnable = we_reg;
    assign mem_byteSelect  = bs_reg;
    assign mem_address     = addr_reg;
    assign mem_writeData   = wd_reg;

    assign instr_readData = instr_rd_reg;
    assign data_readData  = data_rd_reg;
    assign instr_error    = instr_err_reg;
    assign data_error     = data_err_reg;

    assign instr_busy = instr_request && (state_reg != ARB_INSTR_DONE);
    assign data_busy  = data_request  && (state_reg != ARB_DATA_DONE);

endmodule

// File: tb/tb_core_memory_arbiter.sv
// Directed bench for core_memory_arbiter: inputs change on the falling edge,
// outputs are sampled shortly after, with hand-computed expectations.
module tb_core_memory_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_request;
    logic [31:0] instr_address;
    logic [31:0] instr_readData;
    logic        instr_busy;
    logic        instr_error;
    logic        data_request;
    logic        data_writeEnable;
    logic [3:0]  data_byteSelect;
    logic [31:0] data_address;
    logic [31:0] data_writeData;
    logic [31:0] data_readData;
    logic        data_busy;
    logic        data_error;
    logic        mem_cycle;
    logic        mem_writeEnable;
    logic [3:0]  mem_byteSelect;
    logic [31:0] mem_address;
    logic [31:0] mem_writeData;
    logic [31:0] mem_readData;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    core_memory_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .instr_request   (instr_request),
        .instr_address   (instr_address),
        .instr_readData  (instr_readData),
        .instr_busy      (instr_busy),
        .instr_error     (instr_error),
        .data_request    (data_request),
        .data_writeEnable(data_writeEnable),
        .data_byteSelect (data_byteSelect),
        .data_address    (data_address),
        .data_writeData  (data_writeData),
        .data_readData   (data_readData),
        .data_busy       (data_busy),
        .data_error      (data_error),
        .mem_cycle       (mem_cycle),
        .mem_writeEnable (mem_writeEnable),
        .mem_byteSelect  (mem_byteSelect),
        .mem_address     (mem_address),
        .mem_writeData   (mem_writeData),
        .mem_readData    (mem_readData),
        .mem_ack         (mem_ack)
    );

    task automatic test_reset();
        rst = 1'b1; instr_request = 0; instr_address = 0;
        data_request = 0; data_writeEnable = 0; data_byteSelect = 0;
        data_address = 0; data_writeData = 0; mem_readData = 0; mem_ack = 0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (mem_cycle !== 1'b0) begin errors++; $display("FAIL reset_mem_cycle: got %b want 0", mem_cycle); end
        checks++; if (mem_address !== 32'h0 || mem_byteSelect !== 4'h0 || mem_writeEnable !== 1'b0 || mem_writeData !== 32'h0) begin
            errors++; $display("FAIL reset_bus: addr %h bs %h we %b wd %h want all 0", mem_address, mem_byteSelect, mem_writeEnable, mem_writeData); end
        checks++; if (instr_readData !== 32'h0 || data_readData !== 32'h0) begin
            errors++; $display("FAIL reset_readdata: instr %h data %h want 0", instr_readData, data_readData); end
        checks++; if (instr_error !== 1'b0 || data_error !== 1'b0 || instr_busy !== 1'b0 || data_busy !== 1'b0) begin
            errors++; $display("FAIL reset_flags: ierr %b derr %b ibusy %b dbusy %b want 0", instr_error, data_error, instr_busy, data_busy); end
        rst = 1'b0;
        $display("reset: checked outputs after reset");
    endtask

    task automatic test_round_robin();
        logic [2:0]  exp_data;
        logic [31:0] rd;
        exp_data = 3'b101;  // transaction 0,2 = data, 1 = instr
        @(negedge clk);
        instr_request = 1; instr_address = 32'h400;
        data_request = 1; data_writeEnable = 0; data_byteSelect = 4'hF; data_address = 32'h3000;
        for (int t = 0; t < 3; t++) begin
            #1;
            checks++; if (instr_busy !== 1'b1 || data_busy !== 1'b1 || mem_cycle !== 1'b0) begin
                errors++; $display("FAIL rr_idle_%0d: ibusy %b dbusy %b cyc %b want 1 1 0", t, instr_busy, data_busy, mem_cycle); end
            @(negedge clk);
            rd = 32'hC0DE_0000 + t;
            checks++; if (mem_address !== (exp_data[t] ? 32'h3000 : 32'h400)) begin
                errors++; $display("FAIL rr_grant_%0d: addr %h want %h", t, mem_address, exp_data[t] ? 32'h3000 : 32'h400); end
            mem_ack = 1; mem_readData = rd;
            @(negedge clk);
            mem_ack = 0; #1;
            checks++; if (data_busy !== !exp_data[t] || instr_busy !== exp_data[t]) begin
                errors++; $display("FAIL rr_done_busy_%0d: ibusy %b dbusy %b want %b %b", t, instr_busy, data_busy, exp_data[t], !exp_data[t]); end
            checks++; if ((exp_data[t] ? data_readData : instr_readData) !== rd) begin
                errors++; $display("FAIL rr_readdata_%0d: got %h want %h", t, exp_data[t] ? data_readData : instr_readData, rd); end
            $display("round_robin: transaction %0d granted %s", t, exp_data[t] ? "data" : "instr");
            @(negedge clk);
        end
        instr_request = 0; data_request = 0;
        @(negedge clk);
    endtask

    task automatic test_single_fetch();
        instr_request = 1; instr_address = 32'h100; #1;
        checks++; if (instr_busy !== 1'b1 || mem_cycle !== 1'b0) begin
            errors++; $display("FAIL fetch_req: busy %b cyc %b want 1 0", instr_busy, mem_cycle); end
        @(negedge clk);
        checks++; if (mem_cycle !== 1'b1 || mem_address !== 32'h100 || mem_byteSelect !== 4'hF || mem_writeEnable !== 1'b0) begin
            errors++; $display("FAIL fetch_bus: cyc %b addr %h bs %h we %b want 1 100 f 0", mem_cycle, mem_address, mem_byteSelect, mem_writeEnable); end
        @(negedge clk);
        mem_ack = 1; mem_readData = 32'h1234_5678; #1;
        checks++; if (mem_cycle !== 1'b1 || instr_busy !== 1'b1) begin
            errors++; $display("FAIL fetch_active2: cyc %b busy %b want 1 1", mem_cycle, instr_busy); end
        @(negedge clk);
        mem_ack = 0; #1;
        checks++; if (mem_cycle !== 1'b0 || instr_busy !== 1'b0 || instr_readData !== 32'h1234_5678 || instr_error !== 1'b0) begin
            errors++; $display("FAIL fetch_done: cyc %b busy %b rd %h err %b want 0 0 12345678 0", mem_cycle, instr_busy, instr_readData, instr_error); end
        instr_request = 0;
        @(negedge clk);
        $display("single_fetch: addr 100 read %h", instr_readData);
    endtask

    task automatic test_store();
        data_request = 1; data_writeEnable = 1; data_byteSelect = 4'h3;
        data_address = 32'h2004; data_writeData = 32'hABCD; #1;
        checks++; if (data_busy !== 1'b1 || instr_busy !== 1'b0) begin
            errors++; $display("FAIL store_req: dbusy %b ibusy %b want 1 0", data_busy, instr_busy); end
        @(negedge clk);
        checks++; if (mem_cycle !== 1'b1 || mem_writeEnable !== 1'b1 || mem_byteSelect !== 4'h3 || mem_address !== 32'h2004 || mem_writeData !== 32'hABCD) begin
            errors++; $display("FAIL store_bus: cyc %b we %b bs %h addr %h wd %h want 1 1 3 2004 abcd", mem_cycle, mem_writeEnable, mem_byteSelect, mem_address, mem_writeData); end
        mem_ack = 1; #1;
        checks++; if (data_busy !== 1'b1) begin errors++; $display("FAIL store_ack_busy: got %b want 1", data_busy); end
        @(negedge clk);
        mem_ack = 0; #1;
        checks++; if (data_busy !== 1'b0 || mem_cycle !== 1'b0 || data_error !== 1'b0 || instr_busy !== 1'b0) begin
            errors++; $display("FAIL store_done: dbusy %b cyc %b err %b ibusy %b want 0 0 0 0", data_busy, mem_cycle, data_error, instr_busy); end
        data_request = 0; data_writeEnable = 0;
        @(negedge clk);
        $display("store: addr 2004 data abcd lanes 3");
    endtask

    task automatic test_timeout();
        data_request = 1; data_writeEnable = 0; data_byteSelect = 4'hF; data_address = 32'h5000;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk); #1;
            checks++; if (mem_cycle !== 1'b1 || data_busy !== 1'b1 || data_error !== 1'b0) begin
                errors++; $display("FAIL timeout_active_%0d: cyc %b busy %b err %b want 1 1 0", c, mem_cycle, data_busy, data_error); end
        end
        @(negedge clk); #1;
        checks++; if (mem_cycle !== 1'b0 || data_busy !== 1'b0 || data_error !== 1'b1 || data_readData !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL timeout_done: cyc %b busy %b err %b rd %h want 0 0 1 ffffffff", mem_cycle, data_busy, data_error, data_readData); end
        data_request = 0;
        @(negedge clk); #1;
        checks++; if (data_error !== 1'b0) begin errors++; $display("FAIL timeout_pulse: err %b want 0", data_error); end
        $display("timeout: data read %h after 4 active cycles", data_readData);
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        data_request = 1; data_address = 32'h6000;
        @(negedge clk); #1;
        checks++; if (mem_cycle !== 1'b1) begin errors++; $display("FAIL rstmid_active: cyc %b want 1", mem_cycle); end
        rst = 1;
        @(negedge clk);
        mem_ack = 1; mem_readData = 32'h7777_7777; #1;
        checks++; if (mem_cycle !== 1'b0 || mem_address !== 32'h0 || data_readData !== 32'h0 || data_error !== 1'b0) begin
            errors++; $display("FAIL rstmid_reset: cyc %b addr %h rd %h err %b want 0 0 0 0", mem_cycle, mem_address, data_readData, data_error); end
        data_request = 0;
        @(negedge clk);
        rst = 0; mem_ack = 0;
        @(negedge clk); #1;
        checks++; if (mem_cycle !== 1'b0 || data_readData !== 32'h0 || data_busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_after: cyc %b rd %h busy %b want 0 0 0", mem_cycle, data_readData, data_busy); end
        $display("reset_mid_access: late ack ignored");
    endtask

    task automatic test_dropped_request();
        instr_request = 1; instr_address = 32'h700;
        @(negedge clk);
        checks++; if (mem_cycle !== 1'b1 || mem_address !== 32'h700) begin
            errors++; $display("FAIL drop_grant: cyc %b addr %h want 1 700", mem_cycle, mem_address); end
        instr_request = 0; data_request = 1; data_writeEnable = 0; data_address = 32'h8000; #1;
        checks++; if (instr_busy !== 1'b0 || data_busy !== 1'b1 || mem_cycle !== 1'b1) begin
            errors++; $display("FAIL drop_withdrawn: ibusy %b dbusy %b cyc %b want 0 1 1", instr_busy, data_busy, mem_cycle); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (mem_cycle !== 1'b1 || mem_address !== 32'h700) begin
            errors++; $display("FAIL drop_held: cyc %b addr %h want 1 700", mem_cycle, mem_address); end
        mem_ack = 1; mem_readData = 32'h9999_9999;
        @(negedge clk);
        mem_ack = 0; #1;
        checks++; if (mem_cycle !== 1'b0 || instr_error !== 1'b0 || instr_readData !== 32'h0 || data_busy !== 1'b1) begin
            errors++; $display("FAIL drop_done: cyc %b err %b rd %h dbusy %b want 0 0 0 1", mem_cycle, instr_error, instr_readData, data_busy); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (mem_cycle !== 1'b1 || mem_address !== 32'h8000) begin
            errors++; $display("FAIL drop_next_grant: cyc %b addr %h want 1 8000", mem_cycle, mem_address); end
        mem_ack = 1; mem_readData = 32'hAAAA_5555;
        @(negedge clk);
        mem_ack = 0; #1;
        checks++; if (data_readData !== 32'hAAAA_5555 || data_busy !== 1'b0) begin
            errors++; $display("FAIL drop_data_done: rd %h busy %b want aaaa5555 0", data_readData, data_busy); end
        data_request = 0;
        @(negedge clk);
        $display("dropped_request: fetch discarded, data read %h", data_readData);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_fetch();
        test_store();
        test_timeout();
        test_reset_mid_access();
        test_dropped_request();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_memory_arbiter.md
Name: core_memory_arbiter

Overview:
- Shares the core's single external memory port between the instruction-fetch requester and the data load/store requester.
- Sequences each access as one bus transaction. Drives the per-requester busy flags consumed by pipeline flow control as fetch/load-store stall sources.
- Sits between the core pipeline and the core's memory interface.
- Includes a bus-timeout watchdog so a missing acknowledge cannot hang the pipeline.

Parameters:
- TIMEOUT_CYCLES, 255, cycles waited for mem_ack before forcing error completion (1..65535).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- instr_request  in  1  fetch requester wants an access; held until completion
- instr_address  in  32  fetch word address; stable while instr_request is high
- instr_readData  out  32  fetched word; valid in the completion cycle
- instr_busy  out  1  fetch request pending and not completing this cycle
- instr_error  out  1  1-cycle pulse with completion when the access timed out
- data_request  in  1  load/store requester wants an access
- data_writeEnable  in  1  1 = store, 0 = load
- data_byteSelect  in  4  byte lanes
- data_address  in  32  data address
- data_writeData  in  32  store data
- data_readData  out  32  load data; valid in the completion cycle
- data_busy  out  1  data request pending and not completing this cycle
- data_error  out  1  1-cycle timeout pulse with completion
- mem_cycle  out  1  bus transaction active
- mem_writeEnable  out  1  bus write
- mem_byteSelect  out  4  bus byte lanes
- mem_address  out  32  bus address
- mem_writeData  out  32  bus write data
- mem_readData  in  32  bus read data
- mem_ack  in  1  bus completion strobe; ignored when mem_cycle is low

Behaviour:
- States: IDLE, INSTR_ACTIVE, DATA_ACTIVE, INSTR_DONE, DATA_DONE.
- IDLE transitions:
  - data_request only -> DATA_ACTIVE.
  - instr_request only -> INSTR_ACTIVE.
  - Both high: grant the requester not granted last (round-robin bit lastGrantData). Reset value of lastGrantData = 0, so data wins the first conflict.
  - On grant, latch the requester's address, write enable, byte select and write data. For fetch: writeEnable = 0, byteSelect = 4'hF, writeData = 0.
- *_ACTIVE:
  - mem_cycle = 1; bus outputs come from the latched registers.
  - On mem_ack: capture mem_readData into the requester's readData register -> *_DONE.
  - Else if the timeout counter reaches TIMEOUT_CYCLES-1: load 32'hFFFFFFFF into readData, set the error flag -> *_DONE.
- Timeout counter:
  - Cleared on grant; increments each ACTIVE cycle without mem_ack.
  - With TIMEOUT_CYCLES = N, an unacknowledged access completes after N ACTIVE cycles.
- *_DONE: mem_cycle = 0, lasts one cycle.
  - The requester's busy = 0; readData is valid.
  - instr_error/data_error = 1 this cycle only if timed out.
  - Then -> IDLE.
  - A request still high in the following IDLE cycle is a new transaction.
- Busy (combinational):
  - instr_busy = instr_request && state != INSTR_DONE.
  - data_busy = data_request && state != DATA_DONE.
- Latency: request in IDLE at cycle 0; mem_cycle high at cycle 1; ack at cycle k >= 1 gives busy low at k+1. Minimum access is 3 cycles from request to IDLE.
- readData registers hold their value until the next completion for that requester.
- Requester dropping request mid-transaction: the bus transaction still runs to ack or timeout, then the result is discarded. No error is raised.
- mem_ack in IDLE/DONE: ignored.
- Reset values:
  - state IDLE, mem_cycle 0.
  - All mem_* outputs 0, readData registers 0.
  - Error outputs 0, counter 0, lastGrantData 0.
- Reset asserted mid-transaction: next edge forces IDLE and mem_cycle 0. A late ack is ignored.

Decomposition:
- Shared core package: state enum (ARB_IDLE..ARB_DATA_DONE), MEM_ERROR_DATA = 32'hFFFFFFFF, address/data width constants (32).
- One natural sub-module: memory_timeout_counter (clear, enable, expired output, TIMEOUT_CYCLES parameter).

Test Plan:
- Single fetch: instr_request=1, address 0x100, ack on 2nd ACTIVE cycle with readData 0x12345678 -> mem_cycle high 2 cycles, mem_address 0x100, byteSelect 0xF; instr_busy low one cycle with instr_readData 0x12345678.
- Store: data_request, writeEnable=1, byteSelect 0x3, address 0x2004, writeData 0xABCD -> bus carries those values; data_busy drops the cycle after ack; instr_busy unaffected.
- Conflict round-robin: both requests held across 3 transactions -> grants data, instr, data; each busy drops only in its own DONE cycle.
- Timeout: TIMEOUT_CYCLES=4, no ack -> completion after 4 ACTIVE cycles, data_readData 0xFFFFFFFF, data_error pulses exactly 1 cycle.
- Reset mid-access: assert rst in DATA_ACTIVE, then ack next cycle -> mem_cycle 0 after the edge; no DONE; outputs at reset values.
- Dropped request: instr_request falls in INSTR_ACTIVE -> mem_cycle stays until ack; no instr_error; next IDLE grants a pending data request.
